// File: rtl/kronos_hcu.sv
// Kronos hazard control unit: per-register scoreboard of in-flight writes, drives ID stall.
// Optional WB-cycle operand forwarding is enabled by defining KRONOS_HCU_FWD_EN.
module kronos_hcu #(
   parameter int CW = 2
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       id_vld_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_rs1_rd_i,
   input  logic       id_rs2_rd_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_rd_write_i,
   input  logic       ex_rdy_i,
   input  logic       regwr_en_i,
   input  logic [4:0] regwr_sel_i,
   output logic       stall_o,
   output logic       fwd_rs1_o,
   output logic       fwd_rs2_o,
   output logic       busy_o,
   output logic       err_o
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] cnt_q [32];
   logic [CW-1:0] cnt_d [32];
   logic          err_q, err_d;

   logic [CW-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
   logic          hz_rs1, hz_rs2, hz_full;
   logic          issue, inc, dec;
   logic          busy_any;

   assign cnt_rs1 = cnt_q[id_rs1_i];
   assign cnt_rs2 = cnt_q[id_rs2_i];
   assign cnt_rd  = cnt_q[id_rd_i];
   assign cnt_wb  = cnt_q[regwr_sel_i];

`ifdef KRONOS_HCU_FWD_EN
   // The "pending inc" term uses the raw ID request rather than the issue event,
   // otherwise forwarding would feed back through stall.
   logic wb_hit_rs1, wb_hit_rs2, rd_pend_rs1, rd_pend_rs2;
   assign wb_hit_rs1  = regwr_en_i & (regwr_sel_i == id_rs1_i);
   assign wb_hit_rs2  = regwr_en_i & (regwr_sel_i == id_rs2_i);
   assign rd_pend_rs1 = id_vld_i & id_rd_write_i & (id_rd_i == id_rs1_i);
   assign rd_pend_rs2 = id_vld_i & id_rd_write_i & (id_rd_i == id_rs2_i);
   assign fwd_rs1_o   = id_rs1_rd_i & (id_rs1_i != 5'd0) & wb_hit_rs1
                        & (cnt_rs1 == CNT_ONE) & ~rd_pend_rs1;
   assign fwd_rs2_o   = id_rs2_rd_i & (id_rs2_i != 5'd0) & wb_hit_rs2
                        & (cnt_rs2 == CNT_ONE) & ~rd_pend_rs2;
`else
   assign fwd_rs1_o = 1'b0;
   assign fwd_rs2_o = 1'b0;
`endif

   assign hz_rs1  = id_rs1_rd_i & (id_rs1_i != 5'd0) & (cnt_rs1 != '0) & ~fwd_rs1_o;
   assign hz_rs2  = id_rs2_rd_i & (id_rs2_i != 5'd0) & (cnt_rs2 != '0) & ~fwd_rs2_o;
   assign hz_full = id_rd_write_i & (id_rd_i != 5'd0) & (cnt_rd == CNT_MAX);

   // Independent of ex_rdy_i so EX handshake logic cannot form a loop through us.
   assign stall_o = id_vld_i & (hz_rs1 | hz_rs2 | hz_full);

   assign issue = id_vld_i & ~stall_o & ex_rdy_i;
   assign inc   = issue & id_rd_write_i & (id_rd_i != 5'd0);
   assign dec   = regwr_en_i & (regwr_sel_i != 5'd0) & (cnt_wb != '0);

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         if (inc && (id_rd_i == 5'(r)) && !(dec && (regwr_sel_i == 5'(r))))
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         else if (dec && (regwr_sel_i == 5'(r)) && !(inc && (id_rd_i == 5'(r))))
            cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
      cnt_d[0] = '0;
   end

   assign err_d = err_q | (regwr_en_i & (regwr_sel_i != 5'd0) & (cnt_wb == '0));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
         err_q <= err_d;
      end
   end

   always_comb begin
      busy_any = 1'b0;
      for (int r = 1; r < 32; r++) busy_any = busy_any | (|cnt_q[r]);
   end

   assign busy_o = busy_any;
   assign err_o  = err_q;

endmodule

// File: tb/tb_kronos_hcu.sv
// Directed self-checking bench for kronos_hcu (CW = 2); expectations follow KRONOS_HCU_FWD_EN.
module tb_kronos_hcu;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_vld, id_rs1_rd, id_rs2_rd, id_rd_write, ex_rdy, regwr_en;
   logic [4:0] id_rs1, id_rs2, id_rd, regwr_sel;
   logic       stall, fwd_rs1, fwd_rs2, busy, err;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef KRONOS_HCU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always #5 clk = ~clk;

   kronos_hcu #(.CW(2)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_vld_i(id_vld), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_rd_i(id_rs1_rd), .id_rs2_rd_i(id_rs2_rd),
      .id_rd_i(id_rd), .id_rd_write_i(id_rd_write), .ex_rdy_i(ex_rdy),
      .regwr_en_i(regwr_en), .regwr_sel_i(regwr_sel),
      .stall_o(stall), .fwd_rs1_o(fwd_rs1), .fwd_rs2_o(fwd_rs2),
      .busy_o(busy), .err_o(err)
   );

   // Apply one cycle of inputs just after the falling edge; checks follow #1 later.
   task automatic drive(input logic vld, input logic [4:0] rs1, input logic r1,
                        input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                        input logic rdw, input logic exr, input logic wen,
                        input logic [4:0] wsel);
      @(negedge clk);
      id_vld = vld; id_rs1 = rs1; id_rs1_rd = r1; id_rs2 = rs2; id_rs2_rd = r2;
      id_rd = rd; id_rd_write = rdw; ex_rdy = exr; regwr_en = wen; regwr_sel = wsel;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_reset();
      drive(1, 5, 1, 0, 0, 5, 1, 1, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_chk++; if (err   !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_chk++; if (fwd_rs1 !== 1'b0 || fwd_rs2 !== 1'b0) begin n_fail++; $display("FAIL reset_fwd: got %b%b want 00", fwd_rs1, fwd_rs2); end
      @(negedge clk); rst_n = 1'b1;
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);   // issue write to x5
      drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);   // reader of x5
      n_chk++; if (busy  !== 1'b1) begin n_fail++; $display("FAIL pend_busy: got %b want 1", busy); end
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pend_stall: got %b want 1", stall); end
      rst_n = 1'b0; #1;
      n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b want 0", stall); end
      @(negedge clk); rst_n = 1'b1;
      drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
      n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL postrst_busy: got %b want 0", busy); end
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL postrst_stall: got %b want 0", stall); end
      n_chk++; if (err   !== 1'b0) begin n_fail++; $display("FAIL postrst_err: got %b want 0", err); end
      idle();
   endtask

   task automatic test_raw();
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);   // addi x5
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall: got %b want 0", stall); end
      for (int i = 0; i < 2; i++) begin
         drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
         n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_wait_stall[%0d]: got %b want 1", i, stall); end
         n_chk++; if (fwd_rs1 !== 1'b0) begin n_fail++; $display("FAIL raw_wait_fwd[%0d]: got %b want 0", i, fwd_rs1); end
      end
      drive(1, 5, 1, 0, 0, 0, 0, 1, 1, 5);   // WB cycle of x5
      n_chk++; if (stall !== !FWD) begin n_fail++; $display("FAIL raw_wb_stall: got %b want %b", stall, !FWD); end
      n_chk++; if (fwd_rs1 !== FWD) begin n_fail++; $display("FAIL raw_wb_fwd: got %b want %b", fwd_rs1, FWD); end
      drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_stall: got %b want 0", stall); end
      n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL raw_after_busy: got %b want 0", busy); end
      // rs2 path, and a non-reading rs2 field must be ignored
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_rs2_stall: got %b want 1", stall); end
      drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_rs2_noread: got %b want 0", stall); end
      drive(0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_novld: got %b want 0", stall); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
      idle();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL raw_rs2_clean: got %b want 0", busy); end
   endtask

   task automatic test_x0();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
         n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall[%0d]: got %b want 0", i, stall); end
         n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL x0_busy[%0d]: got %b want 0", i, busy); end
      end
      idle();
   endtask

   task automatic test_simul();
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);   // cnt[7] -> 1
      drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 7);   // issue x7 write during WB x7
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL simul_issue_stall: got %b want 0", stall); end
      drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (busy  !== 1'b1) begin n_fail++; $display("FAIL simul_busy: got %b want 1", busy); end
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL simul_stall: got %b want 1", stall); end
      n_chk++; if (fwd_rs1 !== 1'b0) begin n_fail++; $display("FAIL simul_fwd: got %b want 0", fwd_rs1); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);   // one WB retires the count of 1
      idle();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_clean: got %b want 0", busy); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
         n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_issue_stall[%0d]: got %b want 0", i, stall); end
      end
      drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_full_stall: got %b want 1", stall); end
      drive(1, 0, 0, 0, 0, 9, 1, 1, 1, 9);   // WB lands; full still seen this cycle
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_wb_stall: got %b want 1", stall); end
      drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_release_stall: got %b want 0", stall); end
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
      idle();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_clean: got %b want 0", busy); end
   endtask

   task automatic test_underflow();
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);   // cnt[4] -> 1
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 12);  // WB to idle x12
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL uf_err_early: got %b want 0", err); end
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (err   !== 1'b1) begin n_fail++; $display("FAIL uf_err_set: got %b want 1", err); end
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL uf_x4_kept: got %b want 1", stall); end
      drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL uf_x12_zero: got %b want 0", stall); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
      idle(); idle();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uf_clean: got %b want 0", busy); end
      n_chk++; if (err  !== 1'b1) begin n_fail++; $display("FAIL uf_err_sticky: got %b want 1", err); end
      rst_n = 1'b0; #1;
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL uf_err_rst: got %b want 0", err); end
      @(negedge clk); rst_n = 1'b1;
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      id_vld = 0; id_rs1 = 0; id_rs1_rd = 0; id_rs2 = 0; id_rs2_rd = 0;
      id_rd = 0; id_rd_write = 0; ex_rdy = 0; regwr_en = 0; regwr_sel = 0;
      test_reset();
      test_raw();
      test_x0();
      test_simul();
      test_saturation();
      test_underflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/kronos_hcu.md
# kronos_hcu

Hazard control unit for the Kronos ID stage. It keeps a per-register scoreboard of writes that have left ID but not yet reached the register file. From that scoreboard it stalls ID when an instruction reads a register with a pending write, or would overflow a scoreboard entry. It sits beside `kronos_ID`: it observes the ID→EX issue handshake and the WB register-write port, and drives a stall that gates `pipe_out_vld`.

## Interface
- `CW`, default 2: width of each scoreboard counter. Up to 2^CW−1 outstanding writes per register.
- `clk` in 1: core clock.
- `rstz` in 1: reset, asynchronous, active-low.
- `id_vld` in 1: ID holds a decoded instruction.
- `id_rs1`, `id_rs2` in 5: source register indices.
- `id_rs1_rd`, `id_rs2_rd` in 1: instruction actually reads rs1 / rs2.
- `id_rd` in 5: destination register index.
- `id_rd_write` in 1: instruction writes `id_rd`.
- `ex_rdy` in 1: EX accepts (ID `pipe_out_rdy`).
- `regwr_en` in 1: WB register-write strobe.
- `regwr_sel` in 5: WB destination index.
- `stall` out 1: ID must hold (forces `pipe_out_vld` low).
- `fwd_rs1`, `fwd_rs2` out 1: take operand from `regwr_data` this cycle (see Configuration).
- `busy` out 1: at least one counter is non-zero.
- `err` out 1: sticky; set on writeback to an idle register.

## Operation
- State: `cnt[1..31]`, each CW bits; `err`. x0 has no counter, and every x0 reference is hazard-free.
- Issue event: `issue = id_vld & ~stall & ex_rdy`.
- Increment event: `inc = issue & id_rd_write & (id_rd != 0)`; increments `cnt[id_rd]`.
- Decrement event: `dec = regwr_en & (regwr_sel != 0) & (cnt[regwr_sel] != 0)`; decrements `cnt[regwr_sel]`.
- Same register inc and dec in the same cycle: count unchanged.
- `regwr_en` to a register whose count is 0: no change; `err` ← 1 until reset.
- Per-source hazard: `hz_rsN = id_rsN_rd & (id_rsN != 0) & (cnt[id_rsN] != 0)`, except the forwarding case in Configuration.
- Full hazard: `hz_full = id_rd_write & (id_rd != 0) & (cnt[id_rd] == 2^CW−1)`.
- `stall = id_vld & (hz_rs1 | hz_rs2 | hz_full)`.
- Outputs are combinational from registered state plus current inputs. There is no internal FSM beyond the counters.
- `busy = |cnt`.

## Timing
- Reset (async assert, sync deassert via the pipeline reset tree): all `cnt` = 0, `err` = 0.
- Output values while in reset: `stall` = 0, `busy` = 0, `fwd_*` = 0.
- A counter updates on the clk edge that ends the cycle containing the event. An increment is visible to the next instruction in ID one cycle after issue.
- Without forwarding, a dependent instruction stalls through the WB cycle and issues the cycle after `regwr_en`. This costs 0 extra cycles relative to the write landing in the regfile.
- `stall` never depends on `ex_rdy`, so there is no combinational loop with EX.
- `rstz` asserted mid-operation clears the scoreboard immediately. The pipeline is flushed by the same reset, so no write is left in flight.

## Configuration
- Macro: `KRONOS_HCU_FWD_EN`.
- Defined:
  - If `regwr_en & (regwr_sel == id_rsN) & (cnt[id_rsN] == 1) & ~(inc to that register this cycle)`, then `hz_rsN` = 0 and `fwd_rsN` = 1.
  - ID muxes `regwr_data` into opN, and the dependent instruction issues in the WB cycle.
- Undefined: `fwd_rs1` and `fwd_rs2` are tied 0, and a dependent instruction waits one cycle after WB.

## Test plan
- Reset clear: reset with x5 pending (`cnt` = 1) → after `rstz` rises, `busy` = 0, `stall` = 0, `err` = 0.
- Basic RAW:
  - Stimulus: issue `addi x5` with `ex_rdy` = 1; next cycle `id_vld` with rs1 = x5.
  - Required: `stall` = 1 until `regwr_en`/`regwr_sel` = 5.
  - With `KRONOS_HCU_FWD_EN`: `stall` = 0 and `fwd_rs1` = 1 in the WB cycle.
  - Without `KRONOS_HCU_FWD_EN`: `stall` = 0 in the cycle after WB.
- x0 immunity: stream of instructions with rd = 0 and rs1 = rs2 = 0 → `stall` always 0, `busy` always 0.
- Simultaneous inc/dec: issue a write to x7 in the same cycle as WB to x7 with `cnt[7]` = 1 → `cnt[7]` stays 1, `stall` asserts for a following x7 reader, `fwd_rs1` = 0.
- Saturation (CW = 2): three issues writing x9 with no WB → fourth x9-writer sees `stall` = 1; one WB to x9 → `stall` = 0 next cycle.
- Underflow: `regwr_en` with sel = 12 while `cnt[12]` = 0 → `err` = 1, held until reset, all counters unchanged.
